alu_issue: RTL and testbench

- EX-stage front end for the RV32I core, and the driving end of the ALU interface.
- Accepts decoded-stage instructions with their register values over a valid/ready handshake and builds ALU operands and the 4-bit op code.
- Drives the combinational ALU from a registered issue stage, captures result and flags into an output register, and resolves branches.
- Two-stage pipeline, full throughput, backpressure from writeback.

---
 rtl/alu_pkg.sv | 53 +++++
 rtl/alu_issue_decode.sv | 87 ++++++++
 rtl/alu_issue.sv | 100 ++++++++++
 tb/tb_alu_issue.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: ALU op codes, RV32I opcode/funct3 constants and the decoded-instruction record
// shared by alu_issue and its decoder (build option ALU_ISSUE_JUMP_EN lives in the decoder).
package alu_pkg;
   typedef enum logic [3:0] {
      ALU_ADD  = 4'b0000,
      ALU_SLL  = 4'b0001,
      ALU_SLT  = 4'b0010,
      ALU_SLTU = 4'b0011,
      ALU_XOR  = 4'b0100,
      ALU_SRL  = 4'b0101,
      ALU_OR   = 4'b0110,
      ALU_AND  = 4'b0111,
      ALU_SUB  = 4'b1000,
      ALU_SRA  = 4'b1101
   } alu_op_e;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] F7_BASE    = 7'b0000000;
   localparam logic [6:0] F7_ALT     = 7'b0100000;
   localparam logic [2:0] F3_BEQ     = 3'b000;
   localparam logic [2:0] F3_BNE     = 3'b001;
   localparam logic [2:0] F3_BLT     = 3'b100;
   localparam logic [2:0] F3_BGE     = 3'b101;
   localparam logic [2:0] F3_BLTU    = 3'b110;
   localparam logic [2:0] F3_BGEU    = 3'b111;
   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      alu_op_e     op;
      logic [4:0]  rd;
      logic        we;
      logic        is_branch;
      logic        is_jump;
      logic [2:0]  br_funct3;
      logic        illegal;
      logic [31:0] target;
   } dec_t;
   // Branch outcome from the flags of a SUB of rs1 and rs2; CF is the borrow.
   function automatic logic br_cond(input logic [2:0] f3, input logic zf, input logic cf,
                                    input logic of, input logic sf);
      return f3 == F3_BEQ  ? zf :
             f3 == F3_BNE  ? !zf :
             f3 == F3_BLT  ? (sf ^ of) :
             f3 == F3_BGE  ? !(sf ^ of) :
             f3 == F3_BLTU ? cf :
             f3 == F3_BGEU ? !cf : 1'b0;
   endfunction
endpackage

// File: rtl/alu_issue_decode.sv
// alu_issue_decode: combinational RV32I decode into ALU operands, op code and branch target.
// JAL/JALR are decoded only when ALU_ISSUE_JUMP_EN is defined; otherwise they are illegal.
module alu_issue_decode
   import alu_pkg::*;
(
   input  logic [31:0] instr,
   input  logic [31:0] pc,
   input  logic [31:0] rs1_val,
   input  logic [31:0] rs2_val,
   output dec_t        dec
);
   logic [6:0]  opc;
   logic [6:0]  f7;
   logic [2:0]  f3;
   logic        shift;
   logic [31:0] imm_i;
   logic [31:0] imm_u;
   logic [31:0] imm_b;
   logic [31:0] imm_j;
   logic [31:0] tgt_base;
   logic [31:0] tgt_off;
   assign opc   = instr[6:0];
   assign f3    = instr[14:12];
   assign f7    = instr[31:25];
   assign shift = f3 == 3'b001 || f3 == 3'b101;
   assign imm_i = {{20{instr[31]}}, instr[31:20]};
   assign imm_u = {instr[31:12], 12'b0};
   assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
   // One shared target adder: branch pc+imm_b, JAL pc+imm_j, JALR rs1+imm_i.
   assign tgt_base = opc == OPC_JALR ? rs1_val : pc;
   assign tgt_off  = opc == OPC_JAL ? imm_j : opc == OPC_JALR ? imm_i : imm_b;
   always_comb begin
      dec           = '0;
      dec.op        = ALU_ADD;
      dec.rd        = instr[11:7];
      dec.br_funct3 = f3;
      dec.target    = (tgt_base + tgt_off) & {31'h7FFF_FFFF, opc != OPC_JALR};
      case (opc)
         OPC_OP: begin
            dec.a       = rs1_val;
            dec.b       = rs2_val;
            dec.op      = alu_op_e'({f7[5], f3});
            dec.illegal = !(f7 == F7_BASE || (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101)));
            dec.we      = 1'b1;
         end
         OPC_OP_IMM: begin
            dec.a       = rs1_val;
            dec.b       = shift ? {27'b0, instr[24:20]} : imm_i;
            dec.op      = (f3 == 3'b101 && f7[5]) ? ALU_SRA : alu_op_e'({1'b0, f3});
            dec.illegal = shift && f7 != F7_BASE && f7 != F7_ALT;
            dec.we      = 1'b1;
         end
         OPC_LUI: begin
            dec.b  = imm_u;
            dec.we = 1'b1;
         end
         OPC_AUIPC: begin
            dec.a  = pc;
            dec.b  = imm_u;
            dec.we = 1'b1;
         end
         OPC_BRANCH: begin
            dec.a         = rs1_val;
            dec.b         = rs2_val;
            dec.op        = ALU_SUB;
            dec.is_branch = 1'b1;
            dec.illegal   = f3 == 3'b010 || f3 == 3'b011;
         end
`ifdef ALU_ISSUE_JUMP_EN
         OPC_JAL, OPC_JALR: begin
            dec.a       = pc;
            dec.b       = 32'd4;
            dec.we      = 1'b1;
            dec.is_jump = 1'b1;
         end
`endif
         default: dec.illegal = 1'b1;
      endcase
      dec.we = dec.we && dec.rd != 5'd0 && !dec.illegal;
      if (dec.illegal) begin
         dec.op        = ALU_ADD;
         dec.is_branch = 1'b0;
         dec.is_jump   = 1'b0;
      end
   end
endmodule

// File: rtl/alu_issue.sv
// alu_issue: two-stage EX front end -- S1 holds decoded operands driving the ALU, S2 captures
// result, flags-based branch outcome and target. Optional JAL/JALR via ALU_ISSUE_JUMP_EN.
module alu_issue
   import alu_pkg::*;
#(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_PC_TAG = '0
) (
   input  logic            clk,
   input  logic            n_rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   input  logic [XLEN-1:0] in_rs1_val,
   input  logic [XLEN-1:0] in_rs2_val,
   output logic [XLEN-1:0] alu_a,
   output logic [XLEN-1:0] alu_b,
   output logic [3:0]      alu_op,
   input  logic [XLEN-1:0] alu_out,
   input  logic            alu_zf,
   input  logic            alu_cf,
   input  logic            alu_of,
   input  logic            alu_sf,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [4:0]      out_rd,
   output logic            out_we,
   output logic [XLEN-1:0] out_result,
   output logic            out_br_taken,
   output logic [XLEN-1:0] out_br_target,
   output logic            out_illegal
);
   dec_t            dec;
   dec_t            s1_q, s1_d;
   logic            s1_valid_q, s1_valid_d;
   logic            adv, take;
   logic            out_valid_q, out_valid_d;
   logic [4:0]      out_rd_q, out_rd_d;
   logic            out_we_q, out_we_d;
   logic [XLEN-1:0] out_result_q, out_result_d;
   logic            out_br_taken_q, out_br_taken_d;
   logic [XLEN-1:0] out_br_target_q, out_br_target_d;
   logic            out_illegal_q, out_illegal_d;
   alu_issue_decode u_decode (
      .instr   (in_instr),
      .pc      (in_pc),
      .rs1_val (in_rs1_val),
      .rs2_val (in_rs2_val),
      .dec     (dec)
   );
   always_comb begin
      adv             = !out_valid_q || out_ready;
      in_ready        = !s1_valid_q || adv;
      take            = s1_valid_q && adv;
      s1_valid_d      = in_ready ? in_valid : s1_valid_q;
      s1_d            = (in_valid && in_ready) ? dec : s1_q;
      out_valid_d     = adv ? s1_valid_q : out_valid_q;
      out_rd_d        = take ? s1_q.rd : out_rd_q;
      out_we_d        = take ? s1_q.we : out_we_q;
      out_result_d    = take ? alu_out : out_result_q;
      out_br_target_d = take ? s1_q.target : out_br_target_q;
      out_illegal_d   = take ? s1_q.illegal : out_illegal_q;
      out_br_taken_d  = take ? (s1_q.is_jump || (s1_q.is_branch &&
                        br_cond(s1_q.br_funct3, alu_zf, alu_cf, alu_of, alu_sf))) : out_br_taken_q;
   end
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         s1_valid_q      <= 1'b0;
         s1_q            <= '0;
         out_valid_q     <= 1'b0;
         out_rd_q        <= '0;
         out_we_q        <= 1'b0;
         out_result_q    <= '0;
         out_br_taken_q  <= 1'b0;
         out_br_target_q <= RESET_PC_TAG;
         out_illegal_q   <= 1'b0;
      end else begin
         s1_valid_q      <= s1_valid_d;
         s1_q            <= s1_d;
         out_valid_q     <= out_valid_d;
         out_rd_q        <= out_rd_d;
         out_we_q        <= out_we_d;
         out_result_q    <= out_result_d;
         out_br_taken_q  <= out_br_taken_d;
         out_br_target_q <= out_br_target_d;
         out_illegal_q   <= out_illegal_d;
      end
   end
   assign alu_a         = s1_q.a;
   assign alu_b         = s1_q.b;
   assign alu_op        = s1_q.op;
   assign out_valid     = out_valid_q;
   assign out_rd        = out_rd_q;
   assign out_we        = out_we_q;
   assign out_result    = out_result_q;
   assign out_br_taken  = out_br_taken_q;
   assign out_br_target = out_br_target_q;
   assign out_illegal   = out_illegal_q;
endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed and randomized checks of alu_issue against a behavioural RV32I model;
// a small flag-producing ALU closes the loop on alu_a/alu_b/alu_op.
module tb_alu_issue;
   typedef struct packed {
      logic [4:0]  rd;
      logic        we;
      logic [31:0] result;
      logic        taken;
      logic [31:0] target;
      logic        illegal;
      logic        chk_res;
      logic        ctl;
   } res_t;
   logic        clk = 1'b0;
   logic        n_rst = 1'b0;
   logic        in_valid = 1'b0, in_ready;
   logic [31:0] in_instr = '0, in_pc = '0, in_rs1_val = '0, in_rs2_val = '0;
   logic [31:0] alu_a, alu_b, alu_out;
   logic [3:0]  alu_op;
   logic        alu_zf, alu_cf, alu_of, alu_sf;
   logic        out_valid, out_ready = 1'b1;
   logic [4:0]  out_rd;
   logic        out_we, out_br_taken, out_illegal;
   logic [31:0] out_result, out_br_target;
   int          n_cmp = 0, n_bad = 0;
   logic [31:0] ins_q[$], pc_q[$], a_q[$], b_q[$];
   res_t        got_q[$];
   always #5 clk = ~clk;
   alu_issue dut (
      .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
      .in_pc(in_pc), .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .alu_a(alu_a),
      .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out), .alu_zf(alu_zf), .alu_cf(alu_cf),
      .alu_of(alu_of), .alu_sf(alu_sf), .out_valid(out_valid), .out_ready(out_ready),
      .out_rd(out_rd), .out_we(out_we), .out_result(out_result), .out_br_taken(out_br_taken),
      .out_br_target(out_br_target), .out_illegal(out_illegal)
   );
   // ALU stand-in: result plus flags; CF/OF are meaningful for ADD and SUB only.
   logic [32:0] sum_w, dif_w;
   assign sum_w = {1'b0, alu_a} + {1'b0, alu_b};
   assign dif_w = {1'b0, alu_a} - {1'b0, alu_b};
   always_comb begin
      case (alu_op)
         4'b0000: alu_out = sum_w[31:0];
         4'b1000: alu_out = dif_w[31:0];
         4'b0001: alu_out = alu_a << alu_b[4:0];
         4'b0010: alu_out = {31'b0, $signed(alu_a) < $signed(alu_b)};
         4'b0011: alu_out = {31'b0, alu_a < alu_b};
         4'b0100: alu_out = alu_a ^ alu_b;
         4'b0101: alu_out = alu_a >> alu_b[4:0];
         4'b0110: alu_out = alu_a | alu_b;
         4'b0111: alu_out = alu_a & alu_b;
         4'b1101: alu_out = $unsigned($signed(alu_a) >>> alu_b[4:0]);
         default: alu_out = 32'hDEAD_BEEF;
      endcase
   end
   assign alu_zf = alu_out == 32'd0;
   assign alu_sf = alu_out[31];
   assign alu_cf = alu_op == 4'b0000 ? sum_w[32] : alu_op == 4'b1000 ? dif_w[32] : 1'b0;
   assign alu_of = alu_op == 4'b0000 ? (alu_a[31] == alu_b[31] && sum_w[31] != alu_a[31]) :
                   alu_op == 4'b1000 ? (alu_a[31] != alu_b[31] && dif_w[31] != alu_a[31]) : 1'b0;

   function automatic logic [31:0] arith(input logic [2:0] f3, input bit alt,
                                         input logic [31:0] x, input logic [31:0] y);
      case (f3)
         3'd0: return alt ? x - y : x + y;
         3'd1: return x << y[4:0];
         3'd2: return {31'b0, $signed(x) < $signed(y)};
         3'd3: return {31'b0, x < y};
         3'd4: return x ^ y;
         3'd5: return alt ? $unsigned($signed(x) >>> y[4:0]) : x >> y[4:0];
         3'd6: return x | y;
         default: return x & y;
      endcase
   endfunction

   // Architectural outcome of one instruction, straight from the RV32I semantics.
   function automatic res_t model(input logic [31:0] ins, input logic [31:0] pc,
                                  input logic [31:0] a, input logic [31:0] b);
      res_t        e;
      logic [6:0]  opc, f7;
      logic [2:0]  f3;
      logic [31:0] ii, iu, ib, ij;
      bit          sh;
      opc = ins[6:0];
      f7  = ins[31:25];
      f3  = ins[14:12];
      ii  = {{20{ins[31]}}, ins[31:20]};
      iu  = {ins[31:12], 12'b0};
      ib  = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      ij  = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      sh  = f3 == 3'd1 || f3 == 3'd5;
      e = '0;
      e.rd = ins[11:7];
      e.illegal = 1'b1;
      case (opc)
         7'b0110011: if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) begin
            e.illegal = 0; e.we = 1; e.chk_res = 1; e.result = arith(f3, f7[5], a, b);
         end
         7'b0010011: if (!sh || f7 == 7'h00 || f7 == 7'h20) begin
            e.illegal = 0; e.we = 1; e.chk_res = 1;
            e.result = arith(f3, f3 == 3'd5 && f7[5], a, sh ? {27'b0, ins[24:20]} : ii);
         end
         7'b0110111: begin e.illegal = 0; e.we = 1; e.chk_res = 1; e.result = iu; end
         7'b0010111: begin e.illegal = 0; e.we = 1; e.chk_res = 1; e.result = pc + iu; end
         7'b1100011: if (f3 != 3'd2 && f3 != 3'd3) begin
            e.illegal = 0; e.ctl = 1; e.target = pc + ib;
            case (f3)
               3'd0: e.taken = a == b;
               3'd1: e.taken = a != b;
               3'd4: e.taken = $signed(a) < $signed(b);
               3'd5: e.taken = $signed(a) >= $signed(b);
               3'd6: e.taken = a < b;
               default: e.taken = a >= b;
            endcase
         end
`ifdef ALU_ISSUE_JUMP_EN
         7'b1101111: begin
            e.illegal = 0; e.we = 1; e.chk_res = 1; e.result = pc + 4; e.taken = 1; e.ctl = 1;
            e.target = pc + ij;
         end
         7'b1100111: begin
            e.illegal = 0; e.we = 1; e.chk_res = 1; e.result = pc + 4; e.taken = 1; e.ctl = 1;
            e.target = (a + ii) & ~32'd1;
         end
`endif
         default: ;
      endcase
      e.we = e.we && e.rd != 0;
      return e;
   endfunction

   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd);
      return {f7, 5'd2, 5'd1, f3, rd, 7'b0110011};
   endfunction
   function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [2:0] f3);
      return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
   endfunction
   function automatic logic [31:0] rnd_val();
      case ($urandom_range(0, 6))
         0: return 32'h0;
         1: return 32'h7FFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'hFFFF_FFFF;
         4: return $urandom_range(0, 40);
         default: return $urandom;
      endcase
   endfunction
   function automatic logic [31:0] rnd_instr();
      logic [31:0] r;
      logic [6:0]  f7;
      r  = $urandom;
      f7 = r[26:25] == 2'd0 ? r[31:25] : r[27] ? 7'h20 : 7'h00;
      case ($urandom_range(0, 9))
         0, 1, 2: return {f7, r[24:7], 7'b0110011};
         3, 4:    return {f7, r[24:7], 7'b0010011};
         5:       return {r[31:7], 7'b0110111};
         6:       return {r[31:7], 7'b0010111};
         7:       return {r[31:7], 7'b1100011};
         8:       return {r[31:7], r[0] ? 7'b1101111 : 7'b1100111};
         default: return r;
      endcase
   endfunction

   task automatic issue_one(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] r1,
                            input logic [31:0] r2, output res_t g, output int lat,
                            output logic [31:0] b_s, output logic [3:0] op_s, output bit to);
      int k = 0;
      bit f = 0;
      in_instr = ins; in_pc = pc; in_rs1_val = r1; in_rs2_val = r2; in_valid = 1; out_ready = 1;
      while (!f && k < 20) begin
         @(negedge clk); f = in_ready;
         @(posedge clk); #1; k++;
      end
      in_valid = 0;
      lat = 1;
      @(negedge clk); b_s = alu_b; op_s = alu_op;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1; lat++;
         @(negedge clk);
      end
      to = !f || !out_valid;
      g = '{out_rd, out_we, out_result, out_br_taken, out_br_target, out_illegal, 1'b0, 1'b0};
      @(posedge clk); #1;
   endtask

   task automatic stream(input int st_lo, input int st_hi, input bit rnd, output bit saw_stall,
                         output bit to);
      int idx = 0, cyc = 0, tail = 0;
      bit fire;
      got_q.delete();
      saw_stall = 0;
      while (tail < 4 && cyc < 3000) begin
         in_valid = idx < ins_q.size() && (!rnd || $urandom_range(0, 3) != 0);
         if (idx < ins_q.size()) begin
            in_instr = ins_q[idx]; in_pc = pc_q[idx]; in_rs1_val = a_q[idx]; in_rs2_val = b_q[idx];
         end
         out_ready = rnd ? $urandom_range(0, 2) != 0 : !(cyc >= st_lo && cyc <= st_hi);
         @(negedge clk);
         fire = in_valid && in_ready;
         if (in_valid && !in_ready) saw_stall = 1;
         if (out_valid && out_ready)
            got_q.push_back('{out_rd, out_we, out_result, out_br_taken, out_br_target, out_illegal, 1'b0, 1'b0});
         @(posedge clk); #1;
         if (fire) idx++;
         if (idx == ins_q.size() && got_q.size() >= ins_q.size()) tail++;
         cyc++;
      end
      in_valid = 0; out_ready = 1;
      to = tail < 4;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if ({out_valid, out_we, out_br_taken, out_illegal, out_rd, in_ready} !== {4'b0, 5'd0, 1'b1}) begin
         n_bad++;
         $display("FAIL reset_ctrl got v=%b we=%b tk=%b ill=%b rd=%0d rdy=%b want 0 0 0 0 0 1",
                  out_valid, out_we, out_br_taken, out_illegal, out_rd, in_ready);
      end
      n_cmp++;
      if ({out_result, out_br_target, alu_a, alu_b, alu_op} !== {128'h0, 4'h0}) begin
         n_bad++;
         $display("FAIL reset_data got res=%h tgt=%h a=%h b=%h op=%h want all zero",
                  out_result, out_br_target, alu_a, alu_b, alu_op);
      end
      @(negedge clk); n_rst = 1;
      @(posedge clk); #1;
   endtask

   task automatic test_add();
      res_t g; int lat; logic [31:0] b_s; logic [3:0] op_s; bit to;
      issue_one(enc_r(7'h00, 3'd0, 5'd3), 32'h0, 32'h7FFF_FFFF, 32'd1, g, lat, b_s, op_s, to);
      n_cmp++;
      if (to || lat != 2) begin n_bad++; $display("FAIL add_latency got %0d (timeout %b) want 2", lat, to); end
      n_cmp++;
      if ({g.result, g.rd, g.we, g.taken, g.illegal} !== {32'h8000_0000, 5'd3, 3'b100}) begin
         n_bad++;
         $display("FAIL add_result got res=%h rd=%0d we=%b tk=%b ill=%b want 80000000 3 1 0 0",
                  g.result, g.rd, g.we, g.taken, g.illegal);
      end
   endtask

   task automatic test_shift_sub();
      res_t g; int lat; logic [31:0] b_s; logic [3:0] op_s; bit to;
      issue_one({7'b0100000, 5'd4, 5'd1, 3'b101, 5'd5, 7'b0010011}, 32'h0, 32'hF000_0000, 32'h0,
                g, lat, b_s, op_s, to);
      n_cmp++;
      if (to || op_s !== 4'b1101 || b_s !== 32'd4) begin
         n_bad++; $display("FAIL srai_issue got op=%b b=%h want 1101 00000004", op_s, b_s);
      end
      n_cmp++;
      if (g.result !== 32'hFF00_0000 || g.we !== 1'b1 || g.rd !== 5'd5) begin
         n_bad++; $display("FAIL srai_result got res=%h we=%b rd=%0d want ff000000 1 5", g.result, g.we, g.rd);
      end
      issue_one(enc_r(7'h20, 3'd0, 5'd0), 32'h0, 32'd5, 32'd3, g, lat, b_s, op_s, to);
      n_cmp++;
      if (to || g.we !== 1'b0 || g.result !== 32'd2 || op_s !== 4'b1000) begin
         n_bad++; $display("FAIL sub_x0 got we=%b res=%h op=%b want 0 00000002 1000", g.we, g.result, op_s);
      end
   endtask

   task automatic test_branch();
      res_t g; int lat; logic [31:0] b_s; logic [3:0] op_s; bit to;
      issue_one(enc_b(13'h1FF0, 3'b110), 32'h100, 32'd1, 32'hFFFF_FFFF, g, lat, b_s, op_s, to);
      n_cmp++;
      if (to || g.taken !== 1'b1 || g.target !== 32'hF0 || g.we !== 1'b0) begin
         n_bad++; $display("FAIL bltu got tk=%b tgt=%h we=%b want 1 000000f0 0", g.taken, g.target, g.we);
      end
      issue_one(enc_b(13'h0020, 3'b101), 32'h400, 32'hFFFF_FFFF, 32'd1, g, lat, b_s, op_s, to);
      n_cmp++;
      if (to || g.taken !== 1'b0 || g.target !== 32'h420 || g.we !== 1'b0) begin
         n_bad++; $display("FAIL bge got tk=%b tgt=%h we=%b want 0 00000420 0", g.taken, g.target, g.we);
      end
   endtask

   task automatic test_illegal();
      res_t g; int lat; logic [31:0] b_s; logic [3:0] op_s; bit to;
      issue_one({25'h0000_1A5, 7'b0001111}, 32'h0, 32'd7, 32'd9, g, lat, b_s, op_s, to);
      n_cmp++;
      if (to || {g.illegal, g.we, g.taken} !== 3'b100) begin
         n_bad++; $display("FAIL illegal_opc got ill=%b we=%b tk=%b want 1 0 0", g.illegal, g.we, g.taken);
      end
      issue_one(enc_r(7'b0000001, 3'd0, 5'd4), 32'h0, 32'd7, 32'd9, g, lat, b_s, op_s, to);
      n_cmp++;
      if (to || {g.illegal, g.we, g.taken} !== 3'b100) begin
         n_bad++; $display("FAIL illegal_f7 got ill=%b we=%b tk=%b want 1 0 0", g.illegal, g.we, g.taken);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] f[8];
      bit stall, to;
      res_t e, g;
      f = '{enc_r(7'h00, 3'd0, 5'd1), enc_r(7'h20, 3'd0, 5'd2), enc_r(7'h00, 3'd4, 5'd3),
            enc_r(7'h00, 3'd6, 5'd4), enc_r(7'h00, 3'd7, 5'd5), enc_r(7'h00, 3'd1, 5'd6),
            enc_r(7'h20, 3'd5, 5'd7), enc_r(7'h00, 3'd3, 5'd8)};
      ins_q.delete(); pc_q.delete(); a_q.delete(); b_q.delete();
      foreach (f[i]) begin ins_q.push_back(f[i]); pc_q.push_back(0); a_q.push_back(rnd_val()); b_q.push_back(rnd_val()); end
      stream(3, 5, 0, stall, to);
      n_cmp++;
      if (to || !stall || got_q.size() != 8) begin
         n_bad++; $display("FAIL b2b_flow got n=%0d stall=%b timeout=%b want 8 1 0", got_q.size(), stall, to);
      end
      foreach (ins_q[i]) begin
         e = model(ins_q[i], pc_q[i], a_q[i], b_q[i]);
         g = i < got_q.size() ? got_q[i] : '0;
         n_cmp++;
         if (g.rd !== e.rd || g.we !== e.we || g.result !== e.result || g.illegal !== e.illegal) begin
            n_bad++;
            $display("FAIL b2b[%0d] got rd=%0d we=%b res=%h ill=%b want rd=%0d we=%b res=%h ill=%b",
                     i, g.rd, g.we, g.result, g.illegal, e.rd, e.we, e.result, e.illegal);
         end
      end
   endtask

   task automatic test_random();
      bit stall, to;
      res_t e, g;
      ins_q.delete(); pc_q.delete(); a_q.delete(); b_q.delete();
      for (int i = 0; i < 300; i++) begin
         ins_q.push_back(rnd_instr());
         pc_q.push_back({$urandom_range(0, 32'h3FFF_FFFF), 2'b00});
         a_q.push_back(rnd_val());
         b_q.push_back($urandom_range(0, 7) == 0 ? a_q[i] : rnd_val());
      end
      stream(0, -1, 1, stall, to);
      n_cmp++;
      if (to || got_q.size() != ins_q.size()) begin
         n_bad++; $display("FAIL rnd_count got %0d timeout=%b want %0d", got_q.size(), to, ins_q.size());
      end
      foreach (ins_q[i]) begin
         e = model(ins_q[i], pc_q[i], a_q[i], b_q[i]);
         g = i < got_q.size() ? got_q[i] : '0;
         n_cmp++;
         if (g.rd !== e.rd || g.we !== e.we || g.taken !== e.taken || g.illegal !== e.illegal ||
             (e.chk_res && g.result !== e.result) || (e.ctl && g.target !== e.target)) begin
            n_bad++;
            $display("FAIL rnd[%0d] ins=%h got rd=%0d we=%b res=%h tk=%b tgt=%h ill=%b want rd=%0d we=%b res=%h tk=%b tgt=%h ill=%b",
                     i, ins_q[i], g.rd, g.we, g.result, g.taken, g.target, g.illegal,
                     e.rd, e.we, e.result, e.taken, e.target, e.illegal);
         end
      end
   endtask

   task automatic test_reset_mid();
      res_t g; int lat; logic [31:0] b_s; logic [3:0] op_s; bit to;
      bit seen = 0;
      in_instr = enc_r(7'h00, 3'd0, 5'd1); in_rs1_val = 32'd100; in_rs2_val = 32'd1;
      in_valid = 1; out_ready = 0;
      @(posedge clk); #1;
      in_instr = enc_r(7'h00, 3'd0, 5'd2);
      @(posedge clk); #1;
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
         n_bad++; $display("FAIL mid_full got v=%b rdy=%b want 1 0", out_valid, in_ready);
      end
      #2 n_rst = 0;
      #1;
      n_cmp++;
      if ({out_valid, out_we, out_br_taken, out_illegal, out_rd, in_ready} !== {4'b0, 5'd0, 1'b1} ||
          {out_result, out_br_target, alu_a, alu_b, alu_op} !== {128'h0, 4'h0}) begin
         n_bad++;
         $display("FAIL mid_reset got v=%b we=%b rd=%0d res=%h tgt=%h op=%h rdy=%b want reset values",
                  out_valid, out_we, out_rd, out_result, out_br_target, alu_op, in_ready);
      end
      in_valid = 0; out_ready = 1;
      @(posedge clk); #1;
      n_rst = 1;
      repeat (3) begin @(negedge clk); seen |= out_valid; @(posedge clk); #1; end
      n_cmp++;
      if (seen) begin n_bad++; $display("FAIL mid_ghost got out_valid=1 want 0 after release"); end
      issue_one(enc_r(7'h00, 3'd0, 5'd9), 32'h0, 32'd5, 32'd6, g, lat, b_s, op_s, to);
      n_cmp++;
      if (to || g.rd !== 5'd9 || g.result !== 32'd11 || lat != 2) begin
         n_bad++; $display("FAIL mid_first got rd=%0d res=%h lat=%0d want 9 0000000b 2", g.rd, g.result, lat);
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_shift_sub();
      test_branch();
      test_illegal();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
